// File: rtl/dp_sequencer.sv
// Boot/run/halt sequencer and instruction decoder driving the single-cycle datapath controls.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes set a sticky flag and halt instead of retiring as NOP.
module dp_sequencer #(
  parameter int BOOT_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       inst,
  input  logic [7:0]       func,
  output logic             rstPC,
  output logic             pcSel,
  output logic             branchSel,
  output logic             jumpSel,
  output logic             regSel,
  output logic             inSel,
  output logic             selDm,
  output logic             selALU,
  output logic             regWrite,
  output logic             nop,
  output logic             ldWnd,
  output logic             memWrite,
  output logic             memRead,
  output logic [1:0]       wndCtrl,
  output logic [2:0]       funcCtrl,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t          state, stateNxt;
  logic [BW-1:0]   bootCnt, bootCntNxt;
  logic            decIllegal;
  logic            isHalt;
  logic            retire;
  logic [2:0]      aluFunc;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Opcode/function classification, independent of sequencer state
  always_comb begin
    decIllegal = 1'b0;
    aluFunc    = 3'b000;
    isHalt     = (inst == 4'b1010);
    case (inst)
      4'b1000: begin
        case (func)
          8'h01:   aluFunc = 3'b000;
          8'h02:   aluFunc = 3'b001;
          8'h04:   aluFunc = 3'b010;
          8'h08:   aluFunc = 3'b011;
          8'h10:   aluFunc = 3'b100;
          8'h20:   aluFunc = 3'b101;
          8'h40:   aluFunc = 3'b000;
          default: decIllegal = 1'b1;
        endcase
      end
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b1010,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: decIllegal = 1'b0;
      default: decIllegal = 1'b1;
    endcase
  end

  assign retire = (state == RUN) && !isHalt && !(TRAP_EN && decIllegal);

  // Next-state logic
  always_comb begin
    stateNxt   = state;
    bootCntNxt = bootCnt;
    case (state)
      BOOT: begin
        if (bootCnt == BW'(BOOT_CYC - 1)) begin
          stateNxt   = RUN;
          bootCntNxt = '0;
        end else begin
          bootCntNxt = bootCnt + BW'(1);
        end
      end
      RUN: begin
        if (isHalt || (TRAP_EN && decIllegal)) stateNxt = HALT;
      end
      HALT: begin
        if (start) begin
          stateNxt   = BOOT;
          bootCntNxt = '0;
        end
      end
      default: begin
        stateNxt   = BOOT;
        bootCntNxt = '0;
      end
    endcase
  end

  // Control outputs: BOOT and HALT hold the PC; RUN decodes inst/func combinationally
  always_comb begin
    rstPC     = 1'b0;
    pcSel     = 1'b0;
    branchSel = 1'b0;
    jumpSel   = 1'b0;
    regSel    = 1'b0;
    inSel     = 1'b0;
    selDm     = 1'b0;
    selALU    = 1'b0;
    regWrite  = 1'b0;
    nop       = 1'b0;
    ldWnd     = 1'b0;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    wndCtrl   = 2'b00;
    funcCtrl  = 3'b000;
    halted    = 1'b0;
    case (state)
      BOOT: rstPC = 1'b1;
      HALT: begin
        rstPC  = 1'b1;
        halted = 1'b1;
      end
      RUN: begin
        if (decIllegal) begin
          nop   = 1'b1;
          pcSel = 1'b1;
        end else begin
          case (inst)
            4'b0000: begin
              memRead  = 1'b1;
              selDm    = 1'b1;
              regWrite = 1'b1;
              pcSel    = 1'b1;
            end
            4'b0001: begin
              memWrite = 1'b1;
              pcSel    = 1'b1;
            end
            4'b0010: jumpSel = 1'b1;
            4'b0100: begin
              branchSel = 1'b1;
              pcSel     = 1'b1;
            end
            4'b1000: begin
              pcSel = 1'b1;
              if (func[6]) begin
                nop = 1'b1;
              end else begin
                regSel   = 1'b1;
                selALU   = 1'b1;
                regWrite = 1'b1;
                funcCtrl = aluFunc;
              end
            end
            4'b1001: begin
              ldWnd   = 1'b1;
              wndCtrl = func[1:0];
              pcSel   = 1'b1;
            end
            4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
              inSel    = 1'b1;
              selALU   = 1'b1;
              regWrite = 1'b1;
              pcSel    = 1'b1;
              funcCtrl = {1'b0, inst[1:0]} + 3'd1;
            end
            default: pcSel = 1'b0;
          endcase
        end
      end
      default: rstPC = 1'b1;
    endcase
  end

  // State, boot counter and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      bootCnt <= '0;
      instret <= '0;
    end else begin
      state   <= stateNxt;
      bootCnt <= bootCntNxt;
      if (retire) instret <= satInc(instret);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal flag, cleared only by restart or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (state == RUN && decIllegal) begin
      illegal <= 1'b1;
    end else if (state == HALT && start) begin
      illegal <= 1'b0;
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: directed scenarios followed by random instruction streams
// compared against an opcode-table reference model.
module tb_dp_sequencer;
  localparam int BOOT_CYC = 4;
  localparam int CNT_W    = 4;
  localparam int MAXC     = (1 << CNT_W) - 1;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [3:0] inst = 4'h0;
  logic [7:0] func = 8'h00;
  logic rstPC, pcSel, branchSel, jumpSel, regSel, inSel, selDm, selALU;
  logic regWrite, nop, ldWnd, memWrite, memRead, halted, illegal;
  logic [1:0] wndCtrl;
  logic [2:0] funcCtrl;
  logic [CNT_W-1:0] instret;

  dp_sequencer #(.BOOT_CYC(BOOT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .inst(inst), .func(func),
    .rstPC(rstPC), .pcSel(pcSel), .branchSel(branchSel), .jumpSel(jumpSel),
    .regSel(regSel), .inSel(inSel), .selDm(selDm), .selALU(selALU),
    .regWrite(regWrite), .nop(nop), .ldWnd(ldWnd), .memWrite(memWrite),
    .memRead(memRead), .wndCtrl(wndCtrl), .funcCtrl(funcCtrl),
    .halted(halted), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Reference model: mode 0=boot, 1=run, 2=halt
  int mMode = 0;
  int mBootLeft = BOOT_CYC;
  int mInstret = 0;
  bit mIllegal = 1'b0;

  logic [18:0] actCtl;
  assign actCtl = {rstPC, pcSel, branchSel, jumpSel, regSel, inSel, selDm, selALU,
                   regWrite, nop, ldWnd, memWrite, memRead, wndCtrl, funcCtrl, halted};

  function automatic bit legal(input logic [3:0] i, input logic [7:0] f);
    if (i == 4'b1000) return ($countones(f) == 1) && !f[7];
    return i inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b1010,
                     4'b1100, 4'b1101, 4'b1110, 4'b1111};
  endfunction

  function automatic logic [18:0] expCtl(input int mode, input logic [3:0] i, input logic [7:0] f);
    logic rPC = 0, pc = 0, br = 0, jm = 0, rs = 0, is = 0, dm = 0, alu = 0;
    logic rw = 0, np = 0, lw = 0, mw = 0, mr = 0, h = 0;
    logic [1:0] w = 2'b00;
    logic [2:0] fc = 3'b000;
    if (mode == 0) begin
      rPC = 1;
    end else if (mode == 2) begin
      rPC = 1; h = 1;
    end else if (!legal(i, f)) begin
      np = 1; pc = 1;
    end else begin
      case (i)
        4'b0000: begin mr = 1; dm = 1; rw = 1; pc = 1; end
        4'b0001: begin mw = 1; pc = 1; end
        4'b0010: jm = 1;
        4'b0100: begin br = 1; pc = 1; end
        4'b1000: begin
          pc = 1;
          if (f[6]) np = 1;
          else begin
            rs = 1; alu = 1; rw = 1;
            for (int b = 0; b < 6; b++) if (f[b]) fc = 3'(b);
          end
        end
        4'b1001: begin lw = 1; w = f[1:0]; pc = 1; end
        4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
          is = 1; alu = 1; rw = 1; pc = 1; fc = 3'(i[1:0] + 1);
        end
        default: pc = 0;
      endcase
    end
    return {rPC, pc, br, jm, rs, is, dm, alu, rw, np, lw, mw, mr, w, fc, h};
  endfunction

  task automatic modelReset();
    mMode = 0; mBootLeft = BOOT_CYC; mInstret = 0; mIllegal = 1'b0;
  endtask

  task automatic modelAdvance(input logic [3:0] i, input logic [7:0] f, input logic s);
    case (mMode)
      0: begin
        mBootLeft--;
        if (mBootLeft == 0) mMode = 1;
      end
      1: begin
        if (i == 4'b1010) mMode = 2;
        else begin
          if (!legal(i, f) && TRAP) begin
            mIllegal = 1'b1;
            mMode = 2;
          end else if (mInstret < MAXC) mInstret++;
        end
      end
      default: begin
        if (s) begin
          mMode = 0; mBootLeft = BOOT_CYC; mIllegal = 1'b0;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag);
    logic [18:0] e;
    e = expCtl(mMode, inst, func);
    nCmp++;
    assert (actCtl === e) else begin
      nBad++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, actCtl, e);
    end
    nCmp++;
    assert (instret === CNT_W'(mInstret)) else begin
      nBad++;
      $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, mInstret);
    end
    nCmp++;
    assert (illegal === mIllegal) else begin
      nBad++;
      $error("FAIL %s illegal observed=%b expected=%b", tag, illegal, mIllegal);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] i, input logic [7:0] f, input logic s);
    @(negedge clk);
    inst = i; func = f; start = s;
    #1 chk(tag);
    @(posedge clk);
    modelAdvance(i, f, s);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1 modelReset();
    chk(tag);
    @(posedge clk);
    #1 chk(tag);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ri;
    logic [7:0] rf;
    doReset("reset");
    for (int k = 0; k < BOOT_CYC; k++) step("boot", 4'b1000, 8'h04, 1'b0);
    for (int k = 0; k < 3; k++) step("alu_sub", 4'b1000, 8'h04, 1'b0);
    step("brz", 4'b0100, 8'h00, 1'b0);
    step("jump", 4'b0010, 8'h00, 1'b0);
    step("wnd", 4'b1001, 8'h02, 1'b0);
    step("load_start_run", 4'b0000, 8'h00, 1'b1);
    step("store", 4'b0001, 8'h00, 1'b0);
    step("addi", 4'b1100, 8'h5a, 1'b0);
    step("ori", 4'b1111, 8'h00, 1'b0);
    step("alu_nop", 4'b1000, 8'h40, 1'b0);
    step("halt", 4'b1010, 8'h00, 1'b0);
    step("halted", 4'b0000, 8'h00, 1'b0);
    step("halted2", 4'b1000, 8'h04, 1'b0);
    step("restart", 4'b0000, 8'h00, 1'b1);
    for (int k = 0; k < BOOT_CYC; k++) step("reboot", 4'b0000, 8'h00, 1'b1);
    step("run_again", 4'b1000, 8'h01, 1'b0);
    step("illegal_alu", 4'b1000, 8'h03, 1'b0);
    step("after_illegal", 4'b0000, 8'h00, 1'b0);
    step("illegal_op", 4'b0011, 8'h00, 1'b0);
    step("after_illegal2", 4'b0001, 8'h00, 1'b1);
    for (int k = 0; k < BOOT_CYC + 1; k++) step("recover", 4'b1000, 8'h10, 1'b1);
    for (int k = 0; k < 20; k++) step("saturate", 4'b1101, 8'h00, 1'b0);
    doReset("midrun_reset");
    for (int k = 0; k < BOOT_CYC + 2; k++) step("post_reset", 4'b1110, 8'h00, 1'b0);
    for (int k = 0; k < 400; k++) begin
      ri = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) rf = 8'(1 << $urandom_range(0, 7));
      else rf = 8'($urandom);
      if ($urandom_range(0, 99) == 0) doReset("rand_reset");
      else step("rand", ri, rf, ($urandom_range(0, 3) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
Control stage directly upstream of the single-cycle datapath. It consumes the datapath's opcode (inst, 4 bits) and function field (func, 8 bits) and drives every datapath control input. A boot/run/halt state machine wraps the decoder:
- BOOT holds the PC in reset for a programmable number of cycles.
- HALT freezes all architectural state.
- A saturating counter tracks retired instructions.

Parameters:
- BOOT_CYC, 4, number of cycles rstPC stays asserted after reset or restart (minimum 1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  restart request; honoured only in HALT.
- inst  in  4  opcode from datapath instOut.
- func  in  8  function/immediate field from datapath funcOut.
- rstPC, pcSel, branchSel, jumpSel, regSel, inSel, selDm, selALU, regWrite, nop, ldWnd, memWrite, memRead  out  1 each  datapath controls.
- wndCtrl  out  2  register-window value for the window register.
- funcCtrl  out  3  ALU function select.
- halted  out  1  high while in HALT.
- illegal  out  1  sticky illegal-opcode flag.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
Interface:
- Single clock clk; rst is asynchronous and active-high.

Reset:
- rst forces state=BOOT, boot counter=0, instret=0, illegal=0.
- During BOOT: rstPC=1 and every other control output is 0 (funcCtrl=0, wndCtrl=0); halted=0.

State machine (state and boot counter are registered):
- BOOT: counter increments each cycle. When counter==BOOT_CYC-1, go to RUN next cycle. rstPC is high for exactly BOOT_CYC cycles.
- RUN: outputs are a purely combinational decode of inst/func (zero-latency, single-cycle). Each RUN cycle that is not HALT, and not illegal-trapped, retires one instruction: instret += 1, saturating at all-ones.
- HALT is entered on the cycle after inst=1010 is decoded in RUN. In HALT:
  - rstPC=1, all write enables low, halted=1, instret frozen.
  - start=1 -> BOOT (counter cleared, illegal cleared, instret kept).
  - start is ignored in BOOT and RUN.
- rst in any state, mid-boot or mid-program, returns immediately to BOOT.

Decode in RUN (all signals not listed are 0):
- 0000 LOAD: memRead, selDm, regWrite, pcSel.
- 0001 STORE: memWrite, pcSel.
- 0010 JUMP: jumpSel. pcSel=0.
- 0100 BRZ: branchSel, pcSel. The datapath prioritises the taken branch over the increment.
- 1000 ALU: regSel, selALU, regWrite, pcSel. func is one-hot:
  - bit0 MOV -> funcCtrl 000
  - bit1 ADD -> 001
  - bit2 SUB -> 010
  - bit3 AND -> 011
  - bit4 OR -> 100
  - bit5 NOT -> 101
  - bit6 NOP -> nop=1, regWrite=0, pcSel=1
  - any other func pattern (zero, multi-hot, bit7) is illegal.
- 1001 WND: ldWnd, wndCtrl=func[1:0], pcSel.
- 1010 HALT: pcSel=0, no writes; retire not counted.
- 1100 ADDI / 1101 SUBI / 1110 ANDI / 1111 ORI: inSel, selALU, regWrite, pcSel; funcCtrl 001/010/011/100 respectively.
- Every other opcode is illegal.

Illegal handling:
- Always treated as NOP: nop=1, pcSel=1, no writes.
- See the optional feature for the trap behaviour.

Outputs:
- No output glitches on state-derived outputs: state, boot counter, illegal and instret are all registered.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an illegal instruction sets illegal=1 (sticky until restart or rst). The next state is HALT, and the instruction is not counted.
- Undefined: an illegal instruction executes as NOP, is counted as retired, and the machine stays in RUN. illegal is tied to 0.

Test Plan:
- Reset with BOOT_CYC=4, rst released at cycle 0 -> rstPC=1 for cycles 0-3, RUN at cycle 4, instret=0.
- RUN with inst=1000, func=0x04 -> regSel=1, selALU=1, regWrite=1, pcSel=1, funcCtrl=010; instret increments by 1 per cycle.
- inst=0100 then inst=0010 -> first cycle branchSel=1, pcSel=1; second cycle jumpSel=1, pcSel=0. inst=1001 with func=0x02 -> ldWnd=1, wndCtrl=10.
- inst=1010 -> halted=1 next cycle with all writes 0 and instret frozen. start while RUN is ignored. start in HALT -> 4 BOOT cycles, then RUN.
- inst=1000 with func=0x03, ILLEGAL_TRAP_EN defined -> nop=1, illegal=1, HALT next cycle. Same stimulus with the macro undefined -> nop=1, instret+1, stays in RUN.
- CNT_W=4, run 20 legal instructions -> instret saturates at 15. Assert rst mid-run -> BOOT immediately and instret=0.
